// File: rtl/spi_master_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_arbiter_if                                           |
// | Brief    : Requester-side and spi_master-side bus of the SPI arbiter.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface spi_master_arbiter_if #(
   parameter int num_req_g        = 4,
   parameter int data_width_g     = 8,
   parameter int bits_of_slaves_g = 2,
   parameter int len_width_g      = 4
);
   logic [num_req_g-1:0]                  req;
   logic [num_req_g*bits_of_slaves_g-1:0] req_slave_addr;
   logic [num_req_g*len_width_g-1:0]      req_len;
   logic [num_req_g*data_width_g-1:0]     req_data;
   logic [num_req_g-1:0]                  gnt;
   logic [num_req_g-1:0]                  data_rd;
   logic [num_req_g-1:0]                  done;
   logic [data_width_g-1:0]               rx_data;
   logic [num_req_g-1:0]                  rx_valid;
   logic                                  fifo_req_data;
   logic [data_width_g-1:0]               fifo_din;
   logic                                  fifo_din_valid;
   logic                                  fifo_empty;
   logic [bits_of_slaves_g-1:0]           spi_slave_addr;
   logic                                  busy;
   logic [data_width_g-1:0]               dout;
   logic                                  dout_valid;

   // Arbiter view
   modport master (
      input  req, req_slave_addr, req_len, req_data,
      input  fifo_req_data, busy, dout, dout_valid,
      output gnt, data_rd, done, rx_data, rx_valid,
      output fifo_din, fifo_din_valid, fifo_empty, spi_slave_addr
   );

   // Client / spi_master view
   modport slave (
      output req, req_slave_addr, req_len, req_data,
      output fifo_req_data, busy, dout, dout_valid,
      input  gnt, data_rd, done, rx_data, rx_valid,
      input  fifo_din, fifo_din_valid, fifo_empty, spi_slave_addr
   );
endinterface
`default_nettype wire

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : spi_master_arbiter                                              |
// | Brief    : Round-robin sharing of one spi_master among several requesters. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module spi_master_arbiter #(
   parameter int num_req_g        = 4,
   parameter int data_width_g     = 8,
   parameter int bits_of_slaves_g = 2,
   parameter int len_width_g      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_master_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(num_req_g);
   localparam int REM_W = len_width_g + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            ptr_q, ptr_d;
   logic [IDX_W-1:0]            win_q, win_d;
   logic [REM_W-1:0]            remaining_q, remaining_d;
   logic                        drain_ok_q, drain_ok_d;
   logic [num_req_g-1:0]        gnt_q, gnt_d;
   logic [num_req_g-1:0]        data_rd_q, data_rd_d;
   logic [num_req_g-1:0]        done_q, done_d;
   logic [num_req_g-1:0]        rx_valid_q, rx_valid_d;
   logic [data_width_g-1:0]     rx_data_q, rx_data_d;
   logic [data_width_g-1:0]     fifo_din_q, fifo_din_d;
   logic                        fifo_din_valid_q, fifo_din_valid_d;
   logic                        fifo_empty_q, fifo_empty_d;
   logic [bits_of_slaves_g-1:0] slave_addr_q, slave_addr_d;

   logic [IDX_W-1:0]            win_sel;
   logic [IDX_W-1:0]            scan_idx;
   logic                        found;

   // First active request at or after the pointer, wrapping around.
   always_comb begin
      win_sel  = ptr_q;
      scan_idx = ptr_q;
      found    = 1'b0;
      for (int i = 0; i < num_req_g; i++) begin
         scan_idx = IDX_W'((int'(ptr_q) + i) % num_req_g);
         if (!found && bus.req[scan_idx]) begin
            win_sel = scan_idx;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      win_d            = win_q;
      remaining_d      = remaining_q;
      drain_ok_d       = drain_ok_q;
      gnt_d            = gnt_q;
      data_rd_d        = '0;
      done_d           = '0;
      rx_valid_d       = '0;
      rx_data_d        = rx_data_q;
      fifo_din_d       = fifo_din_q;
      fifo_din_valid_d = 1'b0;
      fifo_empty_d     = fifo_empty_q;
      slave_addr_d     = slave_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (found) begin
               state_d        = ST_XFER;
               win_d          = win_sel;
               gnt_d          = '0;
               gnt_d[win_sel] = 1'b1;
               ptr_d          = (win_sel == IDX_W'(num_req_g - 1)) ? '0 : win_sel + 1'b1;
               slave_addr_d   = bus.req_slave_addr[win_sel*bits_of_slaves_g +: bits_of_slaves_g];
               remaining_d    = REM_W'(bus.req_len[win_sel*len_width_g +: len_width_g]) + REM_W'(1);
               fifo_empty_d   = 1'b0;
            end
         end
         ST_XFER: begin
            if (bus.fifo_req_data && (remaining_q != '0)) begin
               fifo_din_d       = bus.req_data[win_q*data_width_g +: data_width_g];
               fifo_din_valid_d = 1'b1;
               data_rd_d[win_q] = 1'b1;
               remaining_d      = remaining_q - REM_W'(1);
               if (remaining_q == REM_W'(1)) begin
                  fifo_empty_d = 1'b1;
                  drain_ok_d   = 1'b0;
                  state_d      = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // drain_ok_q marks that two edges have passed since the last TX word.
            if (drain_ok_q && !bus.busy) begin
               done_d  = gnt_q;
               gnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               drain_ok_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (((state_q == ST_XFER) || (state_q == ST_DRAIN)) && bus.dout_valid) begin
         rx_data_d  = bus.dout;
         rx_valid_d = gnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= ST_IDLE;
         ptr_q            <= '0;
         win_q            <= '0;
         remaining_q      <= '0;
         drain_ok_q       <= 1'b0;
         gnt_q            <= '0;
         data_rd_q        <= '0;
         done_q           <= '0;
         rx_valid_q       <= '0;
         rx_data_q        <= '0;
         fifo_din_q       <= '0;
         fifo_din_valid_q <= 1'b0;
         fifo_empty_q     <= 1'b1;
         slave_addr_q     <= '0;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         win_q            <= win_d;
         remaining_q      <= remaining_d;
         drain_ok_q       <= drain_ok_d;
         gnt_q            <= gnt_d;
         data_rd_q        <= data_rd_d;
         done_q           <= done_d;
         rx_valid_q       <= rx_valid_d;
         rx_data_q        <= rx_data_d;
         fifo_din_q       <= fifo_din_d;
         fifo_din_valid_q <= fifo_din_valid_d;
         fifo_empty_q     <= fifo_empty_d;
         slave_addr_q     <= slave_addr_d;
      end
   end

   assign bus.gnt            = gnt_q;
   assign bus.data_rd        = data_rd_q;
   assign bus.done           = done_q;
   assign bus.rx_data        = rx_data_q;
   assign bus.rx_valid       = rx_valid_q;
   assign bus.fifo_din       = fifo_din_q;
   assign bus.fifo_din_valid = fifo_din_valid_q;
   assign bus.fifo_empty     = fifo_empty_q;
   assign bus.spi_slave_addr = slave_addr_q;

endmodule
`default_nettype wire
